// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by pipe_hazard_ctrl and haz_match.
package pipe_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] rd;
      logic             ld;
   } shadow_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

endpackage

// File: rtl/pipe_hazard_ctrl_haz_match.sv
// One source operand compared against the EX/MEM/WB shadow entries.
// Register 0 never matches; the youngest matching entry picks the bypass.
module haz_match
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0] src_i,
   input  shadow_t          ex_i,
   input  shadow_t          mem_i,
   input  shadow_t          wb_i,
   output logic             hit_o,
   output logic             ld_hit_o,
   output logic [1:0]       fwd_o
);

   logic nz;
   logic m_ex;
   logic m_mem;
   logic m_wb;
   logic unused_ld;

   assign nz    = |src_i;
   assign m_ex  = nz & ex_i.v  & (ex_i.rd  == src_i);
   assign m_mem = nz & mem_i.v & (mem_i.rd == src_i);
   assign m_wb  = nz & wb_i.v  & (wb_i.rd  == src_i);

   assign hit_o     = m_ex | m_mem | m_wb;
   assign ld_hit_o  = m_ex & ex_i.ld;
   assign unused_ld = mem_i.ld ^ wb_i.ld;

   always_comb begin
      fwd_o = FWD_RF;
      if (m_ex) begin
         fwd_o = FWD_EX;
      end else if (m_mem) begin
         fwd_o = FWD_MEM;
      end else if (m_wb) begin
         fwd_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock, branch flush and HLT drain controller.
// Define HAZ_FWD_EN for load-use-only stalls plus fwd_a/fwd_b bypass selects.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int STALL_CNT_W = 16
)
(
   input  logic                   clk1,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [REG_W-1:0]       id_rs,
   input  logic [REG_W-1:0]       id_rt,
   input  logic                   id_use_rs,
   input  logic                   id_use_rt,
   input  logic                   id_wr_en,
   input  logic [REG_W-1:0]       id_rd,
   input  logic                   id_is_load,
   input  logic                   id_is_hlt,
   input  logic                   ex_branch_taken,
   output logic                   stall,
   output logic                   bubble,
   output logic                   flush,
   output logic                   fetch_en,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef HAZ_FWD_EN
   ,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b
`endif
);

   state_e                 state_q, state_d;
   shadow_t                ex_q, ex_d;
   shadow_t                mem_q;
   shadow_t                wb_q;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

   logic       hit_a, hit_b;
   logic       ldh_a, ldh_b;
   logic [1:0] sel_a, sel_b;
   logic       hazard;
   logic       run;
   logic       issue;

   haz_match u_rs (
      .src_i    (id_rs),
      .ex_i     (ex_q),
      .mem_i    (mem_q),
      .wb_i     (wb_q),
      .hit_o    (hit_a),
      .ld_hit_o (ldh_a),
      .fwd_o    (sel_a)
   );

   haz_match u_rt (
      .src_i    (id_rt),
      .ex_i     (ex_q),
      .mem_i    (mem_q),
      .wb_i     (wb_q),
      .hit_o    (hit_b),
      .ld_hit_o (ldh_b),
      .fwd_o    (sel_b)
   );

`ifdef HAZ_FWD_EN
   logic unused_hit;
   assign unused_hit = hit_a ^ hit_b;
   assign hazard = (id_use_rs & ldh_a) | (id_use_rt & ldh_b);
   assign fwd_a  = (issue & id_use_rs) ? sel_a : FWD_RF;
   assign fwd_b  = (issue & id_use_rt) ? sel_b : FWD_RF;
`else
   logic unused_fwd;
   assign unused_fwd = ^{ldh_a, ldh_b, sel_a, sel_b};
   assign hazard = (id_use_rs & hit_a) | (id_use_rt & hit_b);
`endif

   // Reset forces the idle output pattern combinationally.
   assign run      = ~rst & (state_q == ST_RUN);
   assign issue    = run & id_valid & ~hazard & ~ex_branch_taken;
   assign stall    = run & id_valid & hazard & ~ex_branch_taken;
   assign bubble   = ~issue;
   assign flush    = run & ex_branch_taken;
   assign fetch_en = run & ~stall;
   assign halted   = ~rst & (state_q == ST_HALT);
   assign stall_cnt = rst ? '0 : cnt_q;

   always_comb begin
      ex_d = '0;
      if (issue && id_wr_en && (id_rd != '0)) begin
         ex_d.v  = 1'b1;
         ex_d.rd = id_rd;
         ex_d.ld = id_is_load;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (issue && id_is_hlt) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!(ex_q.v || mem_q.v || wb_q.v)) state_d = ST_HALT;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q <= ST_RUN;
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         wb_q    <= mem_q;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset.
REQ-002 Parameter: STALL_CNT_W, default 16, width of the stall counter.
REQ-003 Port: clk1  in  1  pipeline clock; every flop updates on its rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: id_valid  in  1  IF/ID holds a valid instruction.
REQ-006 Port: id_rs, id_rt  in  5 each  source register numbers.
REQ-007 Port: id_use_rs, id_use_rt  in  1 each  the instruction reads that source.
REQ-008 Port: id_wr_en, id_rd  in  1, 5  the instruction writes register id_rd.
REQ-009 Port: id_is_load, id_is_hlt  in  1 each  the instruction is a load / the instruction is HLT.
REQ-010 Port: ex_branch_taken  in  1  the branch now in EX resolved taken.
REQ-011 Port: stall  out  1  hold PC and IF/ID.
REQ-012 Port: bubble  out  1  load a NOP into ID/EX.
REQ-013 Port: flush  out  1  invalidate IF/ID.
REQ-014 Port: fetch_en  out  1  PC may advance.
REQ-015 Port: halted  out  1  the pipeline has drained after HLT.
REQ-016 Port: stall_cnt  out  STALL_CNT_W  saturating count of stall cycles.
REQ-017 Port: fwd_a, fwd_b  out  2 each  operand-source selects; present only with HAZ_FWD_EN (see REQ-031).

Function
REQ-018 Shadow pipe:
- The block SHALL keep entries EX, MEM and WB, each holding {v, rd, ld}.
- Every cycle: WB<=MEM, MEM<=EX.
- EX <= {1, id_rd, id_is_load} on issue when id_wr_en=1 and id_rd!=0; otherwise EX <= 0.
REQ-019 Issue SHALL equal: state RUN & id_valid & ~hazard & ~ex_branch_taken.
REQ-020 Hazard (HAZ_FWD_EN undefined): asserted when a used source is nonzero and equals rd of any valid EX, MEM or WB entry. The register file is not write-through.
REQ-021 On hazard:
- stall=1, bubble=1, fetch_en=0.
- The instruction SHALL re-evaluate in the next cycle with no limit on stall length.
REQ-022 On ex_branch_taken=1:
- flush=1 and bubble=1 for exactly that cycle.
- The branch SHALL override hazard and HLT decode.
- The EX entry loaded that cycle SHALL be 0.
REQ-023 State machine: RUN, DRAIN, HALT.
- RUN->DRAIN: HLT issues without a branch-taken in the same cycle.
- DRAIN->HALT: EX, MEM and WB are all invalid.
- HALT is terminal until rst.
REQ-024 In DRAIN and HALT: fetch_en=0, bubble=1 and no issue. halted=1 only in HALT.
REQ-025 stall_cnt SHALL increment in each cycle where stall=1 in RUN, and SHALL saturate at all-ones.
REQ-026 With id_valid=0: stall=0, bubble=1 and the EX entry is 0.

Reset
REQ-027 While rst=1 at a clk1 edge:
- state=RUN, all shadow entries=0, stall_cnt=0.
- Outputs: stall=0, flush=0, bubble=1, fetch_en=0, halted=0, fwd=00.
REQ-028 Reset mid-DRAIN or mid-stall SHALL abandon the operation with no residual state.
REQ-029 fetch_en=1 SHALL begin in the first cycle after rst deasserts.

Configuration
REQ-030 Macro HAZ_FWD_EN undefined: full interlock per REQ-020, and fwd_a/fwd_b are absent.
REQ-031 Macro HAZ_FWD_EN defined:
- Hazard SHALL be only a used source equal to the rd of a valid EX entry with ld=1 (load-use, one stall).
- fwd_a/fwd_b SHALL select per operand, youngest match wins: 01 = EX entry, 10 = MEM entry, 11 = WB entry, 00 = register file.
- Selects SHALL be combinational and are valid when issue=1.

Structure
REQ-032 A shared package pipe_pkg SHALL hold the state encoding, the shadow-entry typedef {v, rd, ld}, the FWD_* select constants and REG_W=5.
REQ-033 The comparator logic SHALL be one sub-module, haz_match: inputs one source and three entries; outputs hit, load-hit and the forward select. It is instantiated once for rs and once for rt.

Verification
REQ-034 ADDI R1,R0,10 followed immediately by ADD R4,R1,R2, HAZ_FWD_EN undefined -> 3 stall cycles, then ADD issues; stall_cnt=3.
REQ-035 Same sequence with HAZ_FWD_EN defined -> no stall; fwd_a=01 on ADD issue.
REQ-036 LW R1 followed by ADD R4,R1,R2, HAZ_FWD_EN defined -> 1 stall, then issue with fwd_a=10.
REQ-037 ex_branch_taken=1 while a hazarded instruction sits in ID -> flush=1 and bubble=1 for 1 cycle; stall=0; EX entry is 0.
REQ-038 HLT issued after ADD R5,R4,R3 -> fetch_en=0 from the next cycle; halted=1 exactly 4 cycles after HLT issue.
REQ-039 rst asserted during DRAIN, then released -> next cycle state=RUN, fetch_en=1, halted=0, stall_cnt=0.
